pong_match_controller: RTL and testbench

- Match sequencer for SpeedPong. It steps the game through idle, serve countdown, rally, point pause and game over.
- Keeps both players' scores and the rally speed level.
- Gates the ball datapath through ball_en and ball_reset.
- Timed by the VGA frame tick, runs on CLOCK_50, and drives the score outputs that the HEX decoders display.

---
 rtl/pong_match_controller.sv | 154 +++++++++++++++
 tb/tb_pong_match_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// SpeedPong match sequencer: idle, serve countdown, rally, point pause and game over.
// Keeps both scores and the rally speed level, and gates the ball datapath.
module pong_match_controller #(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned SERVE_FRAMES   = 120,
  parameter int unsigned POINT_FRAMES   = 60,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned SPEED_MAX      = 7
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       paddle_hit,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [2:0] state,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [2:0] speed,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner
);

  localparam int unsigned FRAME_W = 8;
  localparam int unsigned HITS_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [HITS_W-1:0]   hits_q, hits_d;
  logic                start_q;
  logic [2:0]          speed_d;
  logic [3:0]          score_left_d, score_right_d;
  logic                serve_dir_d;
  logic [1:0]          winner_d;
  logic                start_rise;

  assign start_rise = start_btn & ~start_q;
  assign state      = state_q;

  // Registered state, counters and outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      hits_q      <= '0;
      start_q     <= 1'b0;
      ball_en     <= 1'b0;
      ball_reset  <= 1'b0;
      serve_dir   <= 1'b0;
      speed       <= '0;
      score_left  <= '0;
      score_right <= '0;
      winner      <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      hits_q      <= hits_d;
      start_q     <= start_btn;
      ball_en     <= (state_d == RALLY);
      ball_reset  <= (state_d == SERVE) && (state_q != SERVE);
      serve_dir   <= serve_dir_d;
      speed       <= speed_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      winner      <= winner_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    hits_d        = hits_q;
    speed_d       = speed;
    score_left_d  = score_left;
    score_right_d = score_right;
    serve_dir_d   = serve_dir;
    winner_d      = winner;

    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d       = SERVE;
          frame_d       = FRAME_W'(SERVE_FRAMES);
          hits_d        = '0;
          speed_d       = '0;
          score_left_d  = '0;
          score_right_d = '0;
          serve_dir_d   = 1'b0;
          winner_d      = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          frame_d = frame_q - FRAME_W'(1);
          if (frame_q == FRAME_W'(1)) state_d = RALLY;
        end
      end
      POINT: begin
        if (frame_tick) begin
          frame_d = frame_q - FRAME_W'(1);
          if (frame_q == FRAME_W'(1)) begin
            state_d = SERVE;
            frame_d = FRAME_W'(SERVE_FRAMES);
          end
        end
      end
      RALLY: begin
        if (miss_left || miss_right) begin
          // Any miss ends the rally; a simultaneous double miss scores nobody
          state_d = POINT;
          frame_d = FRAME_W'(POINT_FRAMES);
          speed_d = '0;
          hits_d  = '0;
          if (miss_left && !miss_right) begin
            score_right_d = score_right + 4'd1;
            serve_dir_d   = 1'b0;
            if (score_right_d == 4'(WIN_SCORE)) begin
              state_d  = OVER;
              winner_d = 2'd2;
            end
          end else if (miss_right && !miss_left) begin
            score_left_d = score_left + 4'd1;
            serve_dir_d  = 1'b1;
            if (score_left_d == 4'(WIN_SCORE)) begin
              state_d  = OVER;
              winner_d = 2'd1;
            end
          end
        end else if (paddle_hit) begin
          if (hits_q == HITS_W'(HITS_PER_LEVEL - 1)) begin
            hits_d = '0;
            if (speed < 3'(SPEED_MAX)) speed_d = speed + 3'd1;
          end else begin
            hits_d = hits_q + HITS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// Vector-table bench for pong_match_controller with a scoreboard queue of expected outputs.
module tb_pong_match_controller;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       frame_tick, start_btn, paddle_hit, miss_left, miss_right;
  logic [2:0] state;
  logic       ball_en, ball_reset, serve_dir;
  logic [2:0] speed;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;

  pong_match_controller #(
    .WIN_SCORE(3), .SERVE_FRAMES(3), .POINT_FRAMES(2), .HITS_PER_LEVEL(2), .SPEED_MAX(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .frame_tick(frame_tick), .start_btn(start_btn),
    .paddle_hit(paddle_hit), .miss_left(miss_left), .miss_right(miss_right), .state(state),
    .ball_en(ball_en), .ball_reset(ball_reset), .serve_dir(serve_dir), .speed(speed),
    .score_left(score_left), .score_right(score_right), .winner(winner)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       br;
    logic       sd;
    logic [2:0] sp;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] w;
  } out_t;

  typedef struct packed {
    logic s, t, h, l, r;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic out_t sample();
    out_t o;
    o.st = state; o.en = ball_en; o.br = ball_reset; o.sd = serve_dir;
    o.sp = speed; o.sl = score_left; o.sr = score_right; o.w = winner;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d en=%0d br=%0d sd=%0d sp=%0d sl=%0d sr=%0d w=%0d, expected st=%0d en=%0d br=%0d sd=%0d sp=%0d sl=%0d sr=%0d w=%0d",
               name, got.st, got.en, got.br, got.sd, got.sp, got.sl, got.sr, got.w,
               exp.st, exp.en, exp.br, exp.sd, exp.sp, exp.sl, exp.sr, exp.w);
    end
  endtask

  task automatic v(input logic s, t, h, l, r,
                   input int st, en, br, sd, sp, sl, sr, w);
    vec_t x;
    x.s = s; x.t = t; x.h = h; x.l = l; x.r = r;
    x.exp = '{st: 3'(st), en: 1'(en), br: 1'(br), sd: 1'(sd), sp: 3'(sp),
              sl: 4'(sl), sr: 4'(sr), w: 2'(w)};
    vecs.push_back(x);
  endtask

  // Two-tick point pause ending in a fresh serve
  task automatic point_seq(input int sd, sl, sr);
    v(0,1,0,0,0, 3,0,0,sd,0,sl,sr,0);
    v(0,1,0,0,0, 1,0,1,sd,0,sl,sr,0);
  endtask

  // Three-tick serve countdown releasing the ball
  task automatic serve_seq(input int sd, sl, sr);
    v(0,1,0,0,0, 1,0,0,sd,0,sl,sr,0);
    v(0,1,0,0,0, 1,0,0,sd,0,sl,sr,0);
    v(0,1,0,0,0, 2,1,0,sd,0,sl,sr,0);
  endtask

  task automatic drive_idle();
    start_btn = 0; frame_tick = 0; paddle_hit = 0; miss_left = 0; miss_right = 0;
  endtask

  initial begin
    out_t got, exp, zero;
    zero = '0;
    RESET_N = 1'b0;
    drive_idle();
    #12;
    check("reset_values", sample(), zero);

    // Start and serve countdown, including ignored start pulse in SERVE
    v(1,0,0,0,0, 1,0,1,0,0,0,0,0);
    v(1,0,0,0,0, 1,0,0,0,0,0,0,0);
    v(0,1,0,0,0, 1,0,0,0,0,0,0,0);
    v(0,1,0,0,0, 1,0,0,0,0,0,0,0);
    v(1,0,0,0,0, 1,0,0,0,0,0,0,0);
    v(0,1,0,0,0, 2,1,0,0,0,0,0,0);
    // Eight hits: speed steps at 2nd, 4th, 6th and saturates
    v(0,0,1,0,0, 2,1,0,0,0,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,1,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,1,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,2,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,2,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,3,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,3,0,0,0);
    v(0,0,1,0,0, 2,1,0,0,3,0,0,0);
    v(0,1,0,0,0, 2,1,0,0,3,0,0,0);
    // Right miss scores left; start and miss during POINT are ignored
    v(0,0,0,0,1, 3,0,0,1,0,1,0,0);
    v(1,1,0,1,0, 3,0,0,1,0,1,0,0);
    v(0,1,0,0,0, 1,0,1,1,0,1,0,0);
    serve_seq(1,1,0);
    // Three left misses: right wins
    v(0,0,1,0,0, 2,1,0,1,0,1,0,0);
    v(0,0,0,1,0, 3,0,0,0,0,1,1,0);
    point_seq(0,1,1);
    serve_seq(0,1,1);
    v(0,0,0,1,0, 3,0,0,0,0,1,2,0);
    point_seq(0,1,2);
    serve_seq(0,1,2);
    v(0,0,1,0,0, 2,1,0,0,0,1,2,0);
    v(0,0,1,0,0, 2,1,0,0,1,1,2,0);
    v(0,0,0,1,0, 4,0,0,0,0,1,3,2);
    v(0,0,1,0,0, 4,0,0,0,0,1,3,2);
    v(0,1,0,0,0, 4,0,0,0,0,1,3,2);
    v(1,0,0,0,0, 1,0,1,0,0,0,0,0);
    serve_seq(0,0,0);
    // Double miss with coincident hit: no score, serve_dir held, speed cleared
    v(0,0,0,0,1, 3,0,0,1,0,1,0,0);
    point_seq(1,1,0);
    serve_seq(1,1,0);
    v(0,0,1,0,0, 2,1,0,1,0,1,0,0);
    v(0,0,1,0,0, 2,1,0,1,1,1,0,0);
    v(0,0,1,0,0, 2,1,0,1,1,1,0,0);
    v(0,0,1,1,1, 3,0,0,1,0,1,0,0);
    point_seq(1,1,0);
    serve_seq(1,1,0);
    // Build score 2-1 at speed 2 for the mid-rally reset
    v(0,0,0,1,0, 3,0,0,0,0,1,1,0);
    point_seq(0,1,1);
    serve_seq(0,1,1);
    v(0,0,0,0,1, 3,0,0,1,0,2,1,0);
    point_seq(1,2,1);
    serve_seq(1,2,1);
    v(0,0,1,0,0, 2,1,0,1,0,2,1,0);
    v(0,0,1,0,0, 2,1,0,1,1,2,1,0);
    v(0,0,1,0,0, 2,1,0,1,1,2,1,0);
    v(0,0,1,0,0, 2,1,0,1,2,2,1,0);

    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    foreach (vecs[i]) begin
      start_btn  = vecs[i].s;
      frame_tick = vecs[i].t;
      paddle_hit = vecs[i].h;
      miss_left  = vecs[i].l;
      miss_right = vecs[i].r;
      exp_q.push_back(vecs[i].exp);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      got = sample();
      exp = exp_q.pop_front();
      check($sformatf("vec%0d", i), got, exp);
    end
    drive_idle();

    // Asynchronous reset mid-rally, observed well before the next clock edge
    RESET_N = 1'b0;
    #1;
    check("async_reset_mid_rally", sample(), zero);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("idle_after_reset_release", sample(), zero);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
